// File: rtl/controle_display_quadruplo.sv
// controle_display_quadruplo
//   Converts a signed two's-complement value into the four digit codes and
//   the sign bit for a four-digit seven-segment decoder. The magnitude is
//   turned into BCD by double-dabble, one bit per cycle. Values whose
//   magnitude is above 9999 are shown as four dashes. Leading zeros can
//   optionally be blanked. The digit outputs keep their values until the
//   next conversion completes.
//
// Digit codes: 0..9 = BCD digit, 4'b1010 = blank, 4'b1111 = dash.
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   inicio   in   start request, only looked at while idle
//   valor    in   [LARGURA-1:0] signed value, captured on the accepting edge
//   ocupado  out  high while a conversion is running
//   pronto   out  one-cycle pulse that comes with the output update
//   sinal    out  1 = a negative in-range value is displayed
//   milhar   out  [3:0] thousands digit code
//   centena  out  [3:0] hundreds digit code
//   dezena   out  [3:0] tens digit code
//   unidade  out  [3:0] units digit code
//
// state    | meaning
// ---------+---------------------------------------------------------
// OCIOSO   | idle; waits for inicio and captures valor
// MODULO   | takes the magnitude, checks the range, loads the shifter
// CONVERTE | double-dabble, one bit per cycle, LARGURA cycles
// ESCREVE  | registers the digits and sign, pulses pronto
module controle_display_quadruplo #(
  parameter int LARGURA       = 16,
  parameter bit SUPRIME_ZEROS = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [LARGURA-1:0] valor,
  output logic               ocupado,
  output logic               pronto,
  output logic               sinal,
  output logic [3:0]         milhar,
  output logic [3:0]         centena,
  output logic [3:0]         dezena,
  output logic [3:0]         unidade
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam int SW = 16 + LARGURA;
  localparam logic [3:0] BRANCO = 4'b1010;
  localparam logic [3:0] TRACO  = 4'b1111;

  typedef enum logic [1:0] {OCIOSO, MODULO, CONVERTE, ESCREVE} estado_t;

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] valor_q, valor_d;
  logic [SW-1:0]      sr_q, sr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               estouro_q, estouro_d;
  logic               pronto_q, pronto_d;
  logic               sinal_q, sinal_d;
  logic [3:0]         mil_q, mil_d, cen_q, cen_d, dez_q, dez_d, uni_q, uni_d;

  logic [LARGURA:0]   ext;
  logic [LARGURA:0]   mag;
  logic [SW-1:0]      ajust;
  logic               vazio_m, vazio_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      valor_q   <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      estouro_q <= 1'b0;
      pronto_q  <= 1'b0;
      sinal_q   <= 1'b0;
      mil_q     <= BRANCO;
      cen_q     <= BRANCO;
      dez_q     <= BRANCO;
      uni_q     <= BRANCO;
    end else begin
      estado_q  <= estado_d;
      valor_q   <= valor_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      estouro_q <= estouro_d;
      pronto_q  <= pronto_d;
      sinal_q   <= sinal_d;
      mil_q     <= mil_d;
      cen_q     <= cen_d;
      dez_q     <= dez_d;
      uni_q     <= uni_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    valor_d   = valor_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    estouro_d = estouro_q;
    pronto_d  = 1'b0;
    sinal_d   = sinal_q;
    mil_d     = mil_q;
    cen_d     = cen_q;
    dez_d     = dez_q;
    uni_d     = uni_q;
    ext       = '0;
    mag       = '0;
    ajust     = sr_q;
    vazio_m   = 1'b0;
    vazio_c   = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          valor_d  = valor;
          estado_d = MODULO;
        end
      end

      MODULO: begin
        // One extra bit so the most negative input does not wrap when negated.
        ext       = {valor_q[LARGURA-1], valor_q};
        neg_d     = valor_q[LARGURA-1];
        mag       = neg_d ? (~ext + 1'b1) : ext;
        estouro_d = (mag > (LARGURA+1)'(9999));
        sr_d      = {16'b0, mag[LARGURA-1:0]};
        cnt_d     = CW'(LARGURA);
        estado_d  = CONVERTE;
      end

      CONVERTE: begin
        for (int i = 0; i < 4; i++) begin
          if (ajust[LARGURA+4*i +: 4] >= 4'd5)
            ajust[LARGURA+4*i +: 4] = ajust[LARGURA+4*i +: 4] + 4'd3;
        end
        sr_d  = ajust << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1))
          estado_d = ESCREVE;
      end

      ESCREVE: begin
        pronto_d = 1'b1;
        estado_d = OCIOSO;
        if (estouro_q) begin
          sinal_d = 1'b0;
          mil_d   = TRACO;
          cen_d   = TRACO;
          dez_d   = TRACO;
          uni_d   = TRACO;
        end else begin
          sinal_d = neg_q;
          mil_d   = sr_q[SW-1  -: 4];
          cen_d   = sr_q[SW-5  -: 4];
          dez_d   = sr_q[SW-9  -: 4];
          uni_d   = sr_q[SW-13 -: 4];
          if (SUPRIME_ZEROS) begin
            // A digit is blanked only when every digit to its left is blank.
            vazio_m = (mil_d == 4'd0);
            vazio_c = vazio_m && (cen_d == 4'd0);
            if (vazio_m) mil_d = BRANCO;
            if (vazio_c) cen_d = BRANCO;
            if (vazio_c && (dez_d == 4'd0)) dez_d = BRANCO;
          end
        end
      end

      default: estado_d = OCIOSO;
    endcase
  end

  assign ocupado = (estado_q == CONVERTE) || (estado_q == ESCREVE);
  assign pronto  = pronto_q;
  assign sinal   = sinal_q;
  assign milhar  = mil_q;
  assign centena = cen_q;
  assign dezena  = dez_q;
  assign unidade = uni_q;

endmodule

// File: tb/tb_controle_display_quadruplo.sv
module tb_controle_display_quadruplo;

  logic        clock;
  logic        reset;
  logic        inicio;
  logic [15:0] valor;

  logic        ocupado, pronto, sinal;
  logic [3:0]  milhar, centena, dezena, unidade;
  logic        ocupado_z, pronto_z, sinal_z;
  logic [3:0]  milhar_z, centena_z, dezena_z, unidade_z;

  int tests = 0;
  int fails = 0;

  controle_display_quadruplo #(.LARGURA(16), .SUPRIME_ZEROS(1'b1)) dut (
    .clock(clock), .reset(reset), .inicio(inicio), .valor(valor),
    .ocupado(ocupado), .pronto(pronto), .sinal(sinal),
    .milhar(milhar), .centena(centena), .dezena(dezena), .unidade(unidade)
  );

  controle_display_quadruplo #(.LARGURA(16), .SUPRIME_ZEROS(1'b0)) dut_z (
    .clock(clock), .reset(reset), .inicio(inicio), .valor(valor),
    .ocupado(ocupado_z), .pronto(pronto_z), .sinal(sinal_z),
    .milhar(milhar_z), .centena(centena_z), .dezena(dezena_z), .unidade(unidade_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {sinal, milhar, centena, dezena, unidade} from the decimal value.
  function automatic logic [16:0] modelo(input int v, input bit sz);
    int m;
    logic [3:0] th, ce, de, un;
    m = (v < 0) ? -v : v;
    if (m > 9999) return {1'b0, 16'hFFFF};
    th = 4'(m / 1000);
    ce = 4'((m / 100) % 10);
    de = 4'((m / 10) % 10);
    un = 4'(m % 10);
    if (sz) begin
      if (m < 1000) th = 4'hA;
      if (m < 100)  ce = 4'hA;
      if (m < 10)   de = 4'hA;
    end
    return {(v < 0), th, ce, de, un};
  endfunction

  function automatic logic [16:0] obs1();
    return {sinal, milhar, centena, dezena, unidade};
  endfunction

  function automatic logic [16:0] obs0();
    return {sinal_z, milhar_z, centena_z, dezena_z, unidade_z};
  endfunction

  // Runs one conversion and reports what was measured; the callers compare.
  task automatic converte(input int v, output int lat, output int ocup,
                          output logic pr_after, output logic [16:0] r1,
                          output logic [16:0] r0);
    @(negedge clock);
    valor  = 16'(v);
    inicio = 1'b1;
    @(posedge clock);
    #1;
    inicio = 1'b0;
    valor  = 16'($urandom);
    lat  = -1;
    ocup = 0;
    r1   = '0;
    r0   = '0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      if (pronto) begin
        lat = e;
        r1  = obs1();
        r0  = obs0();
        break;
      end
      if (ocupado) ocup++;
    end
    @(posedge clock);
    #1;
    pr_after = pronto;
  endtask

  task automatic test_reset();
    tests++;
    if ({ocupado, pronto, obs1()} !== {2'b00, 17'h0AAAA}) begin
      fails++;
      $display("FAIL reset_state: got ocupado=%b pronto=%b out=%h, want 0 0 0aaaa",
               ocupado, pronto, obs1());
    end
  endtask

  task automatic test_basic();
    int lat, ocup;
    logic pa;
    logic [16:0] r1, r0;
    converte(1234, lat, ocup, pa, r1, r0);
    tests++;
    if (lat !== 18) begin fails++; $display("FAIL basic_latency: got %0d want 18", lat); end
    tests++;
    if (ocup !== 17) begin fails++; $display("FAIL basic_ocupado_cycles: got %0d want 17", ocup); end
    tests++;
    if (pa !== 1'b0) begin fails++; $display("FAIL basic_pronto_width: pronto still %b next cycle", pa); end
    tests++;
    if (r1 !== modelo(1234, 1'b1)) begin
      fails++; $display("FAIL basic_digits: got %h want %h", r1, modelo(1234, 1'b1));
    end
    tests++;
    if (ocupado !== 1'b0) begin fails++; $display("FAIL basic_ocupado_after: got %b want 0", ocupado); end
  endtask

  task automatic test_boundaries();
    int vals[10] = '{0, 9999, -9999, 10000, -10000, -32768, -42, 1, 32767, 1000};
    int lat, ocup;
    logic pa;
    logic [16:0] r1, r0;
    foreach (vals[i]) begin
      converte(vals[i], lat, ocup, pa, r1, r0);
      tests++;
      if (lat !== 18 || ocup !== 17) begin
        fails++;
        $display("FAIL bound_timing[%0d]: got lat=%0d ocup=%0d want 18 17", vals[i], lat, ocup);
      end
      tests++;
      if (r1 !== modelo(vals[i], 1'b1)) begin
        fails++; $display("FAIL bound_blank[%0d]: got %h want %h", vals[i], r1, modelo(vals[i], 1'b1));
      end
      tests++;
      if (r0 !== modelo(vals[i], 1'b0)) begin
        fails++; $display("FAIL bound_noblank[%0d]: got %h want %h", vals[i], r0, modelo(vals[i], 1'b0));
      end
    end
  endtask

  task automatic test_random();
    int v, lat, ocup;
    logic pa;
    logic [16:0] r1, r0;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0:       v = int'($urandom_range(0, 65535)) - 32768;
        1:       v = int'($urandom_range(0, 24000)) - 12000;
        default: v = int'($urandom_range(0, 200)) - 100;
      endcase
      converte(v, lat, ocup, pa, r1, r0);
      tests++;
      if (lat !== 18 || pa !== 1'b0) begin
        fails++; $display("FAIL rand_timing[%0d]: got lat=%0d pronto_next=%b", v, lat, pa);
      end
      tests++;
      if (r1 !== modelo(v, 1'b1) || r0 !== modelo(v, 1'b0)) begin
        fails++;
        $display("FAIL rand_digits[%0d]: got %h/%h want %h/%h", v, r1, r0,
                 modelo(v, 1'b1), modelo(v, 1'b0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, npr;
    logic [16:0] r1;
    @(negedge clock);
    valor  = 16'd500;
    inicio = 1'b1;
    @(posedge clock);
    lat = -1;
    npr = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      if (pronto) begin lat = e; break; end
    end
    r1 = obs1();
    tests++;
    if (lat !== 18) begin fails++; $display("FAIL held_latency: got %0d want 18", lat); end
    tests++;
    if (r1 !== 17'h0A500) begin fails++; $display("FAIL held_digits: got %h want 0a500", r1); end
    valor = 16'd7;
    @(posedge clock);
    #1;
    inicio = 1'b0;
    valor  = 16'd9;
    tests++;
    if (pronto !== 1'b0) begin fails++; $display("FAIL held_single_pulse: pronto=%b want 0", pronto); end
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      if (pronto) begin
        npr++;
        if (lat < 0) lat = e;
        break;
      end
    end
    tests++;
    if (lat !== 18 || npr !== 1) begin
      fails++; $display("FAIL b2b_latency: got %0d want 18", lat);
    end
    tests++;
    if (obs1() !== 17'h0AAA7) begin fails++; $display("FAIL b2b_digits: got %h want 0aaa7", obs1()); end
  endtask

  task automatic test_reset_mid();
    int lat, ocup, npr;
    logic pa;
    logic [16:0] r1, r0;
    @(negedge clock);
    valor  = 16'd8888;
    inicio = 1'b1;
    @(posedge clock);
    #1;
    inicio = 1'b0;
    repeat (6) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({ocupado, pronto, obs1()} !== {2'b00, 17'h0AAAA}) begin
      fails++;
      $display("FAIL reset_mid: got ocupado=%b pronto=%b out=%h, want 0 0 0aaaa",
               ocupado, pronto, obs1());
    end
    @(negedge clock);
    reset = 1'b0;
    npr = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clock);
      #1;
      if (pronto || ocupado) npr++;
    end
    tests++;
    if (npr !== 0) begin fails++; $display("FAIL reset_no_pronto: got %0d active cycles want 0", npr); end
    converte(8888, lat, ocup, pa, r1, r0);
    tests++;
    if (lat !== 18 || r1 !== 17'h08888) begin
      fails++; $display("FAIL reset_recover: got lat=%0d out=%h want 18 08888", lat, r1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    inicio = 1'b0;
    valor  = '0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controle_display_quadruplo.md
Name: controle_display_quadruplo

Overview:
- Sequential controller that converts a signed two's-complement value into the four BCD digit codes and sign bit consumed by the four-digit seven-segment decoder.
- Takes a value through a start/busy/done handshake.
- Takes the magnitude, checks the range, converts it by iterative double-dabble at one bit per cycle, and applies overflow dashes and leading-zero blanking.
- Holds the registered digit codes steady until the next conversion completes.

Parameters:
- LARGURA, 16, width of signed input value; legal range 15..32.
- SUPRIME_ZEROS, 1, 1 = blank leading zeros; 0 = show all four digits.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- inicio  input  1  start request, sampled only in OCIOSO
- valor  input  LARGURA  signed two's-complement value, sampled on the accepting edge
- ocupado  output  1  high from the edge after acceptance until the result edge
- pronto  output  1  one-cycle pulse, coincident with the output update
- sinal  output  1  1 = negative result displayed
- milhar  output  4  thousands digit code
- centena  output  4  hundreds digit code
- dezena  output  4  tens digit code
- unidade  output  4  units digit code

Behaviour:
- Digit code set:
  - 0..9 = BCD digit.
  - 4'b1010 = blank (the decoder blanks every code that is not 0-9 or F).
  - 4'b1111 = dash.
- Reset (async, any state): FSM goes to OCIOSO. Outputs:
  - ocupado = 0, pronto = 0, sinal = 0.
  - All four digits = 4'b1010.
  - Internal shift register and counter cleared.
  - A conversion in progress is discarded with no pronto.
- FSM states: OCIOSO, MODULO, CONVERTE, ESCREVE.
- OCIOSO:
  - If inicio = 1 at edge k: latch valor, go to MODULO, ocupado = 1.
  - inicio is ignored in every other state and is not queued.
- MODULO (edge k+1):
  - neg = valor[LARGURA-1].
  - mag = |valor|, computed in LARGURA+1 bits so the most-negative value does not wrap.
  - estouro = (mag > 9999).
  - Load shift register: BCD field 16'b0, binary field = mag.
  - Bit counter = LARGURA. Go to CONVERTE.
- CONVERTE (edges k+2 .. k+1+LARGURA, exactly LARGURA cycles):
  - Each cycle: add 3 to every BCD nibble >= 5, then shift the whole register left by 1; decrement the counter.
  - On the last shift, go to ESCREVE.
  - Timing is fixed: the count is not shortened on estouro.
- ESCREVE (edge k+2+LARGURA):
  - Register outputs, pronto = 1 for exactly this cycle, ocupado = 0, go to OCIOSO.
  - estouro = 1: all digits = 4'b1111, sinal = 0.
  - Otherwise: sinal = neg. Digits = BCD nibbles, then leading-zero suppression if SUPRIME_ZEROS = 1:
    - milhar blanked if 0.
    - centena blanked if 0 and milhar blanked.
    - dezena blanked if 0 and centena blanked.
    - unidade is never blanked, so value 0 shows only "0".
- Latency: pronto is high LARGURA+2 edges after the accepting edge (18 with the default).
- A new inicio may be accepted in the same cycle pronto is high, since the FSM is already in OCIOSO.
- Outputs hold their values between pronto pulses. valor changes after the accepting edge have no effect.
- The -0 case cannot occur; sinal = 1 only for a negative in-range value.

Test Plan:
- Reset, then valor = 1234, inicio pulse → after 18 edges pronto = 1 for one cycle; milhar/centena/dezena/unidade = 1/2/3/4, sinal = 0; ocupado high for the 17 cycles between acceptance and the result edge.
- valor = -42 → digits A/A/4/2, sinal = 1; with SUPRIME_ZEROS = 0 → 0/0/4/2, sinal = 1.
- Boundaries:
  - valor = 0 → A/A/A/0, sinal 0.
  - 9999 → 9/9/9/9.
  - -9999 → 9/9/9/9 with sinal 1.
  - 10000, -10000 and -32768 → F/F/F/F, sinal 0, each after the same 18-edge latency.
- inicio held high during a conversion of 500 → pronto pulses once with 0 blanked to A/5/0/0; a second inicio in the pronto cycle with 7 → next pronto 18 edges later shows A/A/A/7.
- Assert reset at CONVERTE cycle 5 of a conversion of 8888 → immediately ocupado = 0, pronto = 0, all digits A, sinal = 0; no pronto afterwards until a new inicio.
